pwm_modulator: RTL and testbench

PWM_MODULATOR -- requirements
Module: pwm_modulator

---
 rtl/pwm_pkg.sv | 16 +
 rtl/dead_time_gen.sv | 81 ++++++++
 rtl/pwm_modulator.sv | 96 +++++++++
 tb/tb_pwm_modulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM modulator slice.
// Holds the dead-time FSM state encoding and the default counter width
// and dead-time length used as parameter defaults by the modules.
package pwm_pkg;

  localparam int unsigned CntWDefault = 10;
  localparam int unsigned DeadDefault = 4;

  typedef enum logic [1:0] {
    StOff,
    StDead,
    StHigh,
    StLow
  } dt_state_e;

endpackage

// File: rtl/dead_time_gen.sv
// Dead-time generator: turns the raw PWM level into complementary high/low
// drives with DEAD cycles of both-low after every raw edge.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   enable       0 forces the FSM to OFF on the next cycle
//   raw          raw PWM level from the counter compare
//   pwm_h        high-side drive, registered
//   pwm_l        low-side drive, registered
module dead_time_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD = DeadDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic pwm_h,
  output logic pwm_l
);

  // Timer counts DEAD-1 down to 0, so the DEAD state lasts exactly DEAD cycles.
  localparam logic [3:0] TimerLoad = 4'(DEAD - 1);

  dt_state_e  state, state_d;
  logic [3:0] timer, timer_d;
  logic       raw_prev;
  logic       raw_edge;

  assign raw_edge = raw ^ raw_prev;

  always_comb begin
    state_d = state;
    timer_d = timer;
    if (!enable) begin
      state_d = StOff;
      timer_d = '0;
    end else begin
      unique case (state)
        StOff: begin
          state_d = StDead;
          timer_d = TimerLoad;
        end
        StHigh, StLow: begin
          if (raw_edge) begin
            state_d = StDead;
            timer_d = TimerLoad;
          end
        end
        StDead: begin
          // A raw edge inside the window restarts it.
          if (raw_edge) begin
            timer_d = TimerLoad;
          end else if (timer == '0) begin
            state_d = raw ? StHigh : StLow;
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StOff;
      timer    <= '0;
      raw_prev <= 1'b0;
      pwm_h    <= 1'b0;
      pwm_l    <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      raw_prev <= raw;
      pwm_h    <= (state_d == StHigh);
      pwm_l    <= (state_d == StLow);
    end
  end

endmodule

// File: rtl/pwm_modulator.sv
// Audio PWM modulator: converts signed samples to offset-binary duty values,
// double-buffers them so duty only changes at period start, compares against
// a free-running counter and drives a dead-time protected half bridge.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         1 = run; 0 = outputs low, counter held at 0
//   sample         16-bit two's-complement sample
//   sample_valid   single-cycle strobe qualifying sample
//   ovr_clr        clears the sticky overrun flag
//   pwm_h, pwm_l   complementary drives with dead time
//   period_start   high on the cycle the running counter is 0
//   overrun        sticky: a pending sample was overwritten before use
module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault,
  parameter int unsigned DEAD  = DeadDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  input  logic        ovr_clr,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        period_start,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] DutyMid = {1'b1, {(CNT_W - 1){1'b0}}};

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] active_duty, active_duty_d;
  logic [CNT_W-1:0] pending, pending_d;
  logic [CNT_W-1:0] conv, duty_eff;
  logic             pending_full, pending_full_d;
  logic             overrun_d;
  logic             load;
  logic             raw;
  logic             sample_unused;

  // Low sample bits below the duty resolution are truncated.
  assign sample_unused = ^sample;

  always_comb begin
    conv            = sample[15 -: CNT_W];
    conv[CNT_W-1]   = ~sample[15];
  end

  assign period_start = enable && (cnt == '0);
  assign load         = period_start && pending_full;
  // Use the incoming duty on the load cycle so the new period starts cleanly.
  assign duty_eff     = load ? pending : active_duty;
  assign raw          = (cnt < duty_eff);

  always_comb begin
    cnt_d          = enable ? cnt + 1'b1 : '0;
    active_duty_d  = load ? pending : active_duty;
    pending_d      = sample_valid ? conv : pending;
    pending_full_d = pending_full;
    if (load)         pending_full_d = 1'b0;
    if (sample_valid) pending_full_d = 1'b1;
    overrun_d = overrun;
    if (ovr_clr) overrun_d = 1'b0;
    if (sample_valid && pending_full && !load) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      active_duty  <= DutyMid;
      pending      <= DutyMid;
      pending_full <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      active_duty  <= active_duty_d;
      pending      <= pending_d;
      pending_full <= pending_full_d;
      overrun      <= overrun_d;
    end
  end

  dead_time_gen #(
    .DEAD(DEAD)
  ) u_dead_time_gen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .raw   (raw),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed bench for pwm_modulator at CNT_W = 8, DEAD = 2.
module tb_pwm_modulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample;
  logic        sample_valid;
  logic        ovr_clr;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_start;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int h_cnt, l_cnt, ov_cnt;

  always #5 clk = ~clk;

  pwm_modulator #(
    .CNT_W(8),
    .DEAD (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample      (sample),
    .sample_valid(sample_valid),
    .ovr_clr     (ovr_clr),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .period_start(period_start),
    .overrun     (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    chk("period_start_timeout", 32'(n < 600), 32'd1);
  endtask

  // Counts drive cycles over one period starting at a period_start cycle.
  task automatic run_period(output int h, output int l, output int ov);
    h  = 0;
    l  = 0;
    ov = 0;
    wait_ps();
    for (int i = 0; i < 256; i++) begin
      h  += int'(pwm_h);
      l  += int'(pwm_l);
      ov += int'(pwm_h & pwm_l);
      step();
    end
  endtask

  task automatic strobe(input logic [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample       = 16'h0000;
    sample_valid = 1'b0;
    ovr_clr      = 1'b0;
    steps(3);
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_pwm_h", 32'(pwm_h), 32'd0);
    chk("rst_pwm_l", 32'(pwm_l), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_pending_full", 32'(dut.pending_full), 32'd0);
    chk("rst_active_duty", 32'(dut.active_duty), 32'd128);
    chk("rst_pending", 32'(dut.pending), 32'd128);

    // Sample 0x0000 -> duty 128
    strobe(16'h0000);
    chk("a_pending_full", 32'(dut.pending_full), 32'd1);
    chk("a_pending", 32'(dut.pending), 32'd128);
    enable = 1'b1;
    #1;
    chk("a_ps_on_enable", 32'(period_start), 32'd1);
    run_period(h_cnt, l_cnt, ov_cnt);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("a_h_cycles", 32'(h_cnt), 32'd126);
    chk("a_l_cycles", 32'(l_cnt), 32'd126);
    chk("a_overlap", 32'(ov_cnt), 32'd0);

    // Sample 0x8000 -> duty 0
    step();
    strobe(16'h8000);
    chk("b_pending", 32'(dut.pending), 32'd0);
    run_period(h_cnt, l_cnt, ov_cnt);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("b_h_cycles", 32'(h_cnt), 32'd0);
    chk("b_l_cycles", 32'(l_cnt), 32'd256);

    // Sample 0x7FFF -> duty 255, dead window restarts on the 1-cycle low pulse
    step();
    strobe(16'h7FFF);
    run_period(h_cnt, l_cnt, ov_cnt);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("c_h_cycles", 32'(h_cnt), 32'd253);
    chk("c_l_cycles", 32'(l_cnt), 32'd0);
    chk("c_overrun", 32'(overrun), 32'd0);

    // Two strobes in one period -> overrun, last sample wins (duty 64)
    steps(3);
    strobe(16'h4000);
    strobe(16'hC000);
    chk("d_overrun_set", 32'(overrun), 32'd1);
    chk("d_pending", 32'(dut.pending), 32'd64);
    run_period(h_cnt, l_cnt, ov_cnt);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("d_h_cycles", 32'(h_cnt), 32'd62);
    chk("d_l_cycles", 32'(l_cnt), 32'd190);
    chk("d_overlap", 32'(ov_cnt), 32'd0);
    chk("d_overrun_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("d_overrun_clr", 32'(overrun), 32'd0);
    // Set and clear on the same cycle: set wins
    step();
    strobe(16'hC000);
    ovr_clr = 1'b1;
    strobe(16'hC000);
    ovr_clr = 1'b0;
    chk("d_set_wins", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("d_overrun_clr2", 32'(overrun), 32'd0);

    // Enable dropped at cnt = 100, then re-enabled
    wait_ps();
    steps(100);
    chk("e_cnt_100", 32'(dut.cnt), 32'd100);
    chk("e_l_before", 32'(pwm_l), 32'd1);
    enable = 1'b0;
    step();
    chk("e_off_h", 32'(pwm_h), 32'd0);
    chk("e_off_l", 32'(pwm_l), 32'd0);
    chk("e_off_ps", 32'(period_start), 32'd0);
    chk("e_off_cnt", 32'(dut.cnt), 32'd0);
    steps(5);
    chk("e_hold_l", 32'(pwm_l), 32'd0);
    chk("e_hold_duty", 32'(dut.active_duty), 32'd64);
    enable = 1'b1;
    #1;
    chk("e_ps_reenable", 32'(period_start), 32'd1);
    step();
    chk("e_dead1_h", 32'(pwm_h), 32'd0);
    chk("e_dead1_l", 32'(pwm_l), 32'd0);
    step();
    chk("e_dead2_h", 32'(pwm_h), 32'd0);
    chk("e_dead2_l", 32'(pwm_l), 32'd0);
    step();
    chk("e_high_after", 32'(pwm_h), 32'd1);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("e_h_cycles", 32'(h_cnt), 32'd62);
    chk("e_l_cycles", 32'(l_cnt), 32'd190);

    // Reset mid-period with a sample strobe on the same cycle
    wait_ps();
    steps(30);
    sample       = 16'h8000;
    sample_valid = 1'b1;
    steps(2);
    chk("f_overrun_pre", 32'(overrun), 32'd1);
    reset = 1'b1;
    step();
    reset        = 1'b0;
    sample_valid = 1'b0;
    chk("f_rst_h", 32'(pwm_h), 32'd0);
    chk("f_rst_l", 32'(pwm_l), 32'd0);
    chk("f_rst_overrun", 32'(overrun), 32'd0);
    chk("f_rst_pending_full", 32'(dut.pending_full), 32'd0);
    chk("f_rst_active_duty", 32'(dut.active_duty), 32'd128);
    chk("f_rst_pending", 32'(dut.pending), 32'd128);
    chk("f_rst_cnt", 32'(dut.cnt), 32'd0);
    run_period(h_cnt, l_cnt, ov_cnt);
    run_period(h_cnt, l_cnt, ov_cnt);
    chk("f_h_cycles", 32'(h_cnt), 32'd126);
    chk("f_l_cycles", 32'(l_cnt), 32'd126);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
